// File: rtl/shift_arb_pkg.sv
// Shared types and the round-robin pick helper for the shift arbiter.
// Imported by the arbiter top and by its rotate unit.
package shift_arb_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } shift_dir_e;

    // Upper bound on requesters the pick helper can search.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef struct packed {
        logic found;
        int   idx;
    } rr_pick_t;

    // First set bit of valid, searching upward from ptr and wrapping at num_req.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input int                 ptr,
                                         input int                 num_req);
        rr_pick_t res;
        int       cand;
        res.found = 1'b0;
        res.idx   = 0;
        for (int k = 0; k < MAX_REQ; k++) begin
            cand = ptr + k;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            if (k < num_req && !res.found && valid[cand[IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational rotator: bits leaving one end re-enter at the other.
// WIDTH must be a power of two so the source index wraps for free.
module barrel_shifter
    import shift_arb_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SHAMT_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]       data,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  shift_dir_e             dir,
    output logic [WIDTH-1:0]       result
);

    logic [SHAMT_WIDTH-1:0] src;

    // Output bit i takes source bit i-shamt (left) or i+shamt (right), modulo WIDTH.
    always_comb begin
        result = '0;
        src    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dir == DIR_RIGHT) begin
                src = SHAMT_WIDTH'(i) + shamt;
            end else begin
                src = SHAMT_WIDTH'(i) - shamt;
            end
            result[i] = data[src];
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one rotate unit among NUM_REQ requesters,
// with a single registered result stage (1-cycle latency, full throughput).
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    localparam int SHAMT_WIDTH = $clog2(WIDTH),
    localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]         req_data,
    input  logic [NUM_REQ-1:0][SHAMT_WIDTH-1:0]   req_shamt,
    input  logic [NUM_REQ-1:0]                    req_dir,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [WIDTH-1:0]                      rsp_data,
    output logic [ID_WIDTH-1:0]                   rsp_id
);

    logic [ID_WIDTH-1:0]    rr_ptr;
    logic                   can_accept;
    rr_pick_t               pick;
    logic                   grant_vld;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic [WIDTH-1:0]       op_data;
    logic [SHAMT_WIDTH-1:0] op_shamt;
    shift_dir_e             op_dir;
    logic [WIDTH-1:0]       rot_data;

    always_comb begin
        can_accept = !rsp_valid || rsp_ready;
        pick       = rr_pick(MAX_REQ'(req_valid), int'(rr_ptr), NUM_REQ);
        grant_idx  = ID_WIDTH'(pick.idx);
        grant_vld  = can_accept && pick.found;
        req_ready  = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
        op_data  = req_data[grant_idx];
        op_shamt = req_shamt[grant_idx];
        op_dir   = shift_dir_e'(req_dir[grant_idx]);
    end

    barrel_shifter #(
        .WIDTH       (WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_rot (
        .data   (op_data),
        .shamt  (op_shamt),
        .dir    (op_dir),
        .result (rot_data)
    );

    // A new accept overrides a drain in the same cycle, so the stage never bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant_vld) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rot_data;
            rsp_id    <= grant_idx;
            if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
